shift_reg_sequencer: RTL and testbench

- Command-driven controller for the team's single-bit SISO shift register (DEPTH bits, registered dout, active-low async reset on that block).
- Accepts CLEAR / WRITE / READ commands with a bit count and direction, then drives the register's en/din/shift_dir.
- Streams write bits in and read bits out over valid/ready handshakes.
- Sits between the bus-side command logic and the shift register instance.

---
 rtl/sr_seq_pkg.sv | 7 +
 rtl/shift_reg_sequencer_if.sv | 25 ++
 rtl/sr_seq_bit_counter.sv | 18 +
 rtl/shift_reg_sequencer.sv | 96 +++++++++
 tb/tb_shift_reg_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sr_seq_pkg.sv
// sr_seq_pkg: shared encodings for the shift register sequencer
package sr_seq_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_CLEAR = 2'd1, OP_WRITE = 2'd2, OP_READ = 2'd3} op_e;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WRITE, S_READ} state_e;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/shift_reg_sequencer_if.sv
// shift_reg_sequencer_if: command, write/read stream and shift register signals of the sequencer
interface shift_reg_sequencer_if
  import sr_seq_pkg::*;
#(
  parameter int LEN_W = 9
);
  logic cmd_valid, cmd_ready, cmd_dir;
  op_e cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic s_valid, s_ready, s_data;
  logic m_valid, m_ready, m_data;
  logic sr_en, sr_din, sr_shift_dir, sr_dout;
  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_len, s_valid, s_data, m_ready,
    input cmd_ready, s_ready, m_valid, m_data
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_dir, cmd_len, s_valid, s_data, m_ready, sr_dout,
    output cmd_ready, s_ready, m_valid, m_data, sr_en, sr_din, sr_shift_dir
  );
  modport sreg (
    input sr_en, sr_din, sr_shift_dir,
    output sr_dout
  );
endinterface

// File: rtl/sr_seq_bit_counter.sv
// sr_seq_bit_counter: loadable saturating down-counter with zero flag
module sr_seq_bit_counter #(
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [LEN_W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  // load wins over decrement; decrement stops at zero
  always_comb cnt_d = load_i ? load_val_i : (dec_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: CLEAR/WRITE/READ controller for a SISO shift register; SR_SEQ_PARITY_EN adds a parity output
module shift_reg_sequencer
  import sr_seq_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LEN_W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_reg_sequencer_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef SR_SEQ_PARITY_EN
  ,
  output logic                  parity
`endif
);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  state_e state_q, state_d;
  logic dir_q, pend_q, m_valid_q, m_data_q, done_q, err_q;
  logic accept, len_ok, w_hs, m_hs, rd_issue, dec, fin, cnt_zero, iss_zero;
  assign accept = state_q == S_IDLE && bus.cmd_valid;
  assign len_ok = bus.cmd_len != '0 && bus.cmd_len <= DEPTH_L;
  assign w_hs = state_q == S_WRITE && bus.s_valid;
  assign m_hs = state_q == S_READ && m_valid_q && bus.m_ready;
  assign rd_issue = state_q == S_READ && !pend_q && (!m_valid_q || bus.m_ready) && !iss_zero;
  assign dec = state_q == S_CLEAR || w_hs || m_hs;
  assign fin = dec && cnt_zero;
  // remaining units of work minus one, so the zero flag marks the final one
  sr_seq_bit_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i ((bus.cmd_op == OP_CLEAR ? DEPTH_L : bus.cmd_len) - 1'b1),
    .dec_i      (dec),
    .zero_o     (cnt_zero)
  );
  // read bits still to be shifted out of the register
  sr_seq_bit_counter #(.LEN_W(LEN_W)) u_iss (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (bus.cmd_len),
    .dec_i      (rd_issue),
    .zero_o     (iss_zero)
  );
  // state register
  always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;
  // next state: bad lengths and NOP stay idle, last unit of work returns to idle
  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = bus.cmd_op == OP_CLEAR ? S_CLEAR : !len_ok ? S_IDLE :
                bus.cmd_op == OP_WRITE ? S_WRITE : bus.cmd_op == OP_READ ? S_READ : S_IDLE;
    else if (fin)
      state_d = S_IDLE;
  end
  // outputs decoded from state plus the write pass-through
  always_comb begin
    bus.cmd_ready = state_q == S_IDLE;
    busy = state_q != S_IDLE;
    bus.s_ready = state_q == S_WRITE;
    bus.sr_en = state_q == S_CLEAR || w_hs || rd_issue;
    bus.sr_din = state_q == S_WRITE && bus.s_data;
    bus.sr_shift_dir = dir_q;
    bus.m_valid = m_valid_q;
    bus.m_data = m_data_q;
    done = done_q;
    err = err_q;
  end
  // direction latch, read pipeline (issue -> dout registered -> capture) and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= DIR_LEFT;
      pend_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      dir_q <= accept ? bus.cmd_dir : dir_q;
      pend_q <= rd_issue;
      m_valid_q <= pend_q || (m_valid_q && !bus.m_ready);
      m_data_q <= pend_q ? bus.sr_dout : m_data_q;
      done_q <= fin;
      err_q <= accept && (bus.cmd_op == OP_WRITE || bus.cmd_op == OP_READ) && !len_ok;
    end
  end
`ifdef SR_SEQ_PARITY_EN
  logic parity_q;
  // running XOR of handshaken bits, restarted by every accepted command
  always_ff @(posedge clk) parity_q <= (rst || accept) ? 1'b0 : parity_q ^ (w_hs && bus.s_data) ^ (m_hs && m_data_q);
  assign parity = parity_q;
`endif
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: directed checks of the sequencer against a behavioural shift register
module tb_shift_reg_sequencer;
  import sr_seq_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic busy, done, err;
  int tests = 0, fails = 0;
  int en_cnt = 0, din_bad = 0, err_cnt = 0, done_cnt = 0;
  logic rdy_at_done = 1'b0;
  logic rdq[$];
  logic [255:0] sr_q = '1;
  logic sr_dout_q = 1'b0;
  shift_reg_sequencer_if #(.LEN_W(9)) bus ();
`ifdef SR_SEQ_PARITY_EN
  logic parity;
`endif
  shift_reg_sequencer dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .err  (err)
`ifdef SR_SEQ_PARITY_EN
    ,
    .parity (parity)
`endif
  );
  always #5 clk = ~clk;
  assign bus.sr_dout = sr_dout_q;
  always @(posedge clk)
    if (bus.sr_en) begin
      sr_dout_q <= bus.sr_shift_dir ? sr_q[0] : sr_q[255];
      sr_q <= bus.sr_shift_dir ? {bus.sr_din, sr_q[255:1]} : {sr_q[254:0], bus.sr_din};
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (bus.sr_en) en_cnt++;
    if (bus.sr_en && bus.sr_din) din_bad++;
    if (err) err_cnt++;
    if (done) begin
      done_cnt++;
      rdy_at_done = bus.cmd_ready;
    end
    if (bus.m_valid && bus.m_ready) rdq.push_back(bus.m_data);
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input op_e op, input logic dir, input logic [8:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_dir = dir;
    bus.cmd_len = len;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input int max, output int n);
    int d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < max) begin
      tick();
      n++;
    end
    chk("done_timeout", done_cnt != d0, 1);
  endtask
  task automatic wr(input logic [7:0] bits, input int k, input bit gaps);
    for (int i = 0; i < k; i++) begin
      if (gaps) begin
        bus.s_valid = 1'b0;
        tick();
      end
      bus.s_valid = 1'b1;
      bus.s_data = bits[k-1-i];
      tick();
    end
    bus.s_valid = 1'b0;
  endtask
  initial begin
    int n, d0, e0, ones;
    logic sv;
    logic [7:0] got;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_NOP;
    bus.cmd_dir = 1'b0;
    bus.cmd_len = '0;
    bus.s_valid = 1'b0;
    bus.s_data = 1'b0;
    bus.m_ready = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_sr", {bus.sr_en, bus.sr_din, bus.sr_shift_dir}, 0);
    rst = 1'b0;
    en_cnt = 0; din_bad = 0; done_cnt = 0; err_cnt = 0;
    cmd(OP_CLEAR, 1'b0, 9'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_WRITE;
    bus.cmd_len = 9'd4;
    wait_done(400, n);
    bus.cmd_valid = 1'b0;
    chk("clr_en_cnt", en_cnt, 256);
    chk("clr_din", din_bad, 0);
    chk("clr_cycles", n, 257);
    chk("clr_ready_at_done", rdy_at_done, 1);
    chk("clr_mem", |sr_q, 0);
    chk("pending_cmd_taken", {busy, bus.s_ready}, 2'b11);
    en_cnt = 0;
    wr(8'b1011, 4, 1'b1);
    wait_done(10, n);
    chk("wr_done_lat", n, 1);
    chk("wr_en_cnt", en_cnt, 4);
    chk("wr_mem", {|sr_q[255:4], sr_q[3:0]}, 5'b01011);
    bus.s_valid = 1'b1;
    bus.s_data = 1'b1;
    tick();
    tick();
    bus.s_valid = 1'b0;
    chk("idle_s_ignored", en_cnt, 4);
    chk("idle_s_ready", bus.s_ready, 0);
    en_cnt = 0;
    rdq.delete();
    bus.m_ready = 1'b1;
    cmd(OP_READ, 1'b0, 9'd256);
    wait_done(800, n);
    chk("rd256_count", rdq.size(), 256);
    ones = 0;
    for (int i = 0; i < 252 && i < rdq.size(); i++) ones += int'(rdq[i]);
    chk("rd256_zero_head", ones, 0);
    got = '0;
    for (int i = 0; i < 4 && 252 + i < rdq.size(); i++) got[3-i] = rdq[252+i];
    chk("rd256_tail", got, 8'b1011);
    chk("rd256_en_cnt", en_cnt, 256);
    chk("rd256_zero_fill", |sr_q, 0);
    chk("rd256_m_valid_end", bus.m_valid, 0);
    d0 = done_cnt;
    e0 = err_cnt;
    cmd(OP_NOP, 1'b0, 9'd5);
    tick();
    chk("nop_idle", busy, 0);
    chk("nop_no_pulse", {done_cnt - d0, err_cnt - e0}, 0);
    en_cnt = 0;
    cmd(OP_WRITE, 1'b0, 9'd0);
    chk("err_w0_idle", busy, 0);
    tick();
    chk("err_w0", err_cnt - e0, 1);
    cmd(OP_READ, 1'b0, 9'd257);
    chk("err_r257_idle", busy, 0);
    tick();
    chk("err_r257", err_cnt - e0, 2);
    chk("err_no_en", en_cnt, 0);
    chk("err_no_done", done_cnt - d0, 0);
    cmd(OP_WRITE, 1'b0, 9'd8);
    wr(8'b11010010, 8, 1'b0);
    wait_done(10, n);
    en_cnt = 0;
    rdq.delete();
    bus.m_ready = 1'b1;
    cmd(OP_READ, 1'b1, 9'd8);
    chk("rd8_dir", bus.sr_shift_dir, 1);
    n = 0;
    while (rdq.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    bus.m_ready = 1'b0;
    tick();
    tick();
    chk("stall_m_valid", bus.m_valid, 1);
    sv = bus.m_data;
    e0 = en_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {bus.m_valid, bus.m_data}, {1'b1, sv});
    end
    chk("stall_no_en", en_cnt, e0);
    bus.m_ready = 1'b1;
    wait_done(100, n);
    got = '0;
    for (int i = 0; i < 8 && i < rdq.size(); i++) got[7-i] = rdq[i];
    chk("rd8_count", rdq.size(), 8);
    chk("rd8_data", got, 8'b01001011);
    chk("rd8_en_cnt", en_cnt, 8);
    bus.m_ready = 1'b0;
    cmd(OP_WRITE, 1'b0, 9'd8);
    wr(8'b101, 3, 1'b0);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    chk("rst_mid_state", {busy, bus.s_ready, bus.cmd_ready, bus.m_valid}, 4'b0010);
    rst = 1'b0;
    tick();
    chk("rst_mid_no_done", done_cnt, d0);
    cmd(OP_CLEAR, 1'b1, 9'd0);
    chk("clr2_started", {busy, bus.sr_en, bus.sr_shift_dir}, 3'b111);
    wait_done(300, n);
    chk("clr2_cycles", n, 257);
    chk("clr2_done", done_cnt - d0, 1);
`ifdef SR_SEQ_PARITY_EN
    chk("par_clear", parity, 0);
    cmd(OP_WRITE, 1'b0, 9'd4);
    wr(8'b1101, 4, 1'b1);
    wait_done(10, n);
    chk("par_write", parity, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
